// File: rtl/input_skew_buffer_if.sv
// ---------------------------------------------------------------------------
// input_skew_buffer_if
//   Groups the router-facing and array-facing signals of input_skew_buffer.
//   Router side : i_data, i_data_valid, i_router_done (into the block),
//                 o_pop_en (out of the block).
//   Array side  : i_array_ready (into the block, 0 = global stall),
//                 o_data, o_data_valid (skewed row data out of the block).
//   Modports:
//     slave  - the skew buffer itself
//     master - the environment driving the skew buffer (router + array)
// ---------------------------------------------------------------------------
interface input_skew_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4
);
  logic [ROWS-1:0][DATA_WIDTH-1:0] i_data;
  logic [ROWS-1:0]                 i_data_valid;
  logic                            i_router_done;
  logic                            i_array_ready;
  logic                            o_pop_en;
  logic [ROWS-1:0][DATA_WIDTH-1:0] o_data;
  logic [ROWS-1:0]                 o_data_valid;

  modport slave (
    input  i_data, i_data_valid, i_router_done, i_array_ready,
    output o_pop_en, o_data, o_data_valid
  );

  modport master (
    output i_data, i_data_valid, i_router_done, i_array_ready,
    input  o_pop_en, o_data, o_data_valid
  );
endinterface

// File: rtl/input_skew_buffer.sv
// ---------------------------------------------------------------------------
// input_skew_buffer
//   Pops words from the input router and applies the diagonal skew required
//   by the systolic array: row r passes through r+1 registers, so row 0 has
//   one advance of latency and row ROWS-1 has ROWS. After the router reports
//   completion the pipeline is flushed with bubbles and o_drain_done pulses.
//   i_array_ready=0 stalls (freezes) the whole block.
//
//   Ports:
//     i_clk, i_nrst   clock, asynchronous active-low reset
//     i_en            start request, sampled in IDLE only
//     i_reg_clear     synchronous clear of all state (highest priority)
//     io_bus          router/array handshake and data (slave modport)
//     o_busy          registered, 1 in STREAM and DRAIN
//     o_drain_done    registered one-cycle completion pulse (DONE state)
//     o_beat_count    accepted router beats (any lane valid), saturating
// ---------------------------------------------------------------------------
module input_skew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_en,
  input  logic                  i_reg_clear,
  input_skew_buffer_if.slave    io_bus,
  output logic                  o_busy,
  output logic                  o_drain_done,
  output logic [CNT_WIDTH-1:0]  o_beat_count
);

  localparam int DRAIN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [DRAIN_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_beat_count, w_beat_count_nxt;
  logic                 r_done_pend, w_done_pend_nxt;
  logic                 r_busy;
  logic                 r_drain_done;

  logic                 w_adv;
  logic                 w_stream;
  logic                 w_pop_en;

  assign w_adv = io_bus.i_array_ready;

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_beat_count_nxt = r_beat_count;
    w_done_pend_nxt  = r_done_pend;
    w_pop_en         = 1'b0;
    w_stream         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_state_nxt      = S_STREAM;
          w_beat_count_nxt = '0;
        end
      end

      S_STREAM: begin
        w_stream = 1'b1;
        w_pop_en = w_adv;
        if (w_adv) begin
          if ((|io_bus.i_data_valid) && (r_beat_count != '1)) begin
            w_beat_count_nxt = r_beat_count + 1'b1;
          end
          // A done seen during a stall is honoured on the next advance;
          // the beat presented on that advance is still captured.
          if (io_bus.i_router_done || r_done_pend) begin
            w_done_pend_nxt = 1'b0;
            if (ROWS == 1) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt     = S_DRAIN;
              w_drain_cnt_nxt = DRAIN_W'(ROWS - 1);
            end
          end
        end else if (io_bus.i_router_done) begin
          w_done_pend_nxt = 1'b1;
        end
      end

      S_DRAIN: begin
        if (w_adv) begin
          w_drain_cnt_nxt = r_drain_cnt - 1'b1;
          if (r_drain_cnt == DRAIN_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_beat_count <= '0;
      r_done_pend  <= 1'b0;
      r_busy       <= 1'b0;
      r_drain_done <= 1'b0;
    end else if (i_reg_clear) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_beat_count <= '0;
      r_done_pend  <= 1'b0;
      r_busy       <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_beat_count <= w_beat_count_nxt;
      r_done_pend  <= w_done_pend_nxt;
      r_busy       <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_DRAIN);
      r_drain_done <= (w_state_nxt == S_DONE);
    end
  end

  // -------------------------------------------------------------------------
  // Skew chains: row r holds r+1 stages, stage 0 in the LSB position.
  // -------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic                       w_ld_vld;
    logic [DATA_WIDTH-1:0]      w_ld_data;
    logic [r:0][DATA_WIDTH-1:0] r_sd, w_sd_nxt;
    logic [r:0]                 r_sv, w_sv_nxt;

    // Bubble outside STREAM; invalid lanes carry zero data.
    assign w_ld_vld  = w_stream & io_bus.i_data_valid[r];
    assign w_ld_data = w_ld_vld ? io_bus.i_data[r] : '0;

    if (r == 0) begin : g_single
      assign w_sd_nxt = w_ld_data;
      assign w_sv_nxt = w_ld_vld;
    end else begin : g_chain
      assign w_sd_nxt = {r_sd[r-1:0], w_ld_data};
      assign w_sv_nxt = {r_sv[r-1:0], w_ld_vld};
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_sd <= '0;
        r_sv <= '0;
      end else if (i_reg_clear) begin
        r_sd <= '0;
        r_sv <= '0;
      end else if (w_adv) begin
        r_sd <= w_sd_nxt;
        r_sv <= w_sv_nxt;
      end
    end

    assign io_bus.o_data[r]       = r_sd[r];
    assign io_bus.o_data_valid[r] = r_sv[r];
  end

  assign io_bus.o_pop_en = w_pop_en;
  assign o_busy          = r_busy;
  assign o_drain_done    = r_drain_done;
  assign o_beat_count    = r_beat_count;

endmodule
